// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types, sizes and skew-index helpers for the systolic-array operand feeder.
package systolic_pkg;

   localparam int N        = 3;
   localparam int DATA_W   = 8;
   localparam int DEPTH    = 2 * N * N;
   localparam int ADDR_W   = $clog2(DEPTH);
   localparam int FEED_LEN = 3 * N - 2;
   localparam int CNT_W    = $clog2(FEED_LEN + 1);

   typedef enum logic [1:0] {IDLE, FEED, FIN} state_e;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef data_t [N-1:0]     lanes_t;

   typedef struct packed {
      logic  valid;
      addr_t addr;
   } lane_rd_t;

   // West edge: lane i at beat t carries A[i][t-i] inside the diagonal window.
   function automatic lane_rd_t a_lane_rd(int t, int i);
      lane_rd_t r;
      int col;
      col     = t - i;
      r.valid = (col >= 0) && (col < N);
      r.addr  = r.valid ? ADDR_W'(i * N + col) : '0;
      return r;
   endfunction

   // North edge: lane j at beat t carries B[t-j][j]; B sits above A in storage.
   function automatic lane_rd_t b_lane_rd(int t, int j);
      lane_rd_t r;
      int row;
      row     = t - j;
      r.valid = (row >= 0) && (row < N);
      r.addr  = r.valid ? ADDR_W'(N * N + row * N + j) : '0;
      return r;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Control, operand-load and skewed-edge bus between the feeder and its neighbours.
interface systolic_skew_feeder_if;

   logic                                         enable;
   logic                                         wr_en;
   systolic_pkg::addr_t                          wr_addr;
   systolic_pkg::data_t                          wr_data;
   logic                                         start;
   logic [systolic_pkg::N*systolic_pkg::DATA_W-1:0] a_out;
   logic [systolic_pkg::N*systolic_pkg::DATA_W-1:0] b_out;
   logic [systolic_pkg::N-1:0]                   a_valid;
   logic [systolic_pkg::N-1:0]                   b_valid;
   logic                                         busy;
   logic                                         done;

   modport master (
      output enable, wr_en, wr_addr, wr_data, start,
      input  a_out, b_out, a_valid, b_valid, busy, done
   );

   modport slave (
      input  enable, wr_en, wr_addr, wr_data, start,
      output a_out, b_out, a_valid, b_valid, busy, done
   );

endinterface

// File: rtl/systolic_skew_feeder_ram.sv
// Operand register file: A then B, row-major, one write port and one read port per edge lane.
module systolic_operand_ram
   import systolic_pkg::*;
(
   input  logic                clk_i,
   input  logic                we_i,
   input  addr_t               waddr_i,
   input  data_t               wdata_i,
   input  addr_t [2*N-1:0]     raddr_i,
   output data_t [2*N-1:0]     rdata_o
);

   data_t mem_q [DEPTH];

   // NOTE: the operand store is deliberately not reset; its contents must survive RESET.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      for (int p = 0; p < 2 * N; p++) begin
         rdata_o[p] = mem_q[raddr_i[p]];
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Streams stored A rows / B columns onto the array edges with per-lane diagonal skew.
module systolic_skew_feeder
   import systolic_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   systolic_skew_feeder_if.slave bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   lanes_t           pre_a_q, pre_a_d, pre_b_q, pre_b_d;
   logic [N-1:0]     pre_av_q, pre_av_d, pre_bv_q, pre_bv_d;
   lanes_t           a_out_q, a_out_d, b_out_q, b_out_d;
   logic [N-1:0]     a_vld_q, a_vld_d, b_vld_q, b_vld_d;

   logic             wr_accept;
   logic [CNT_W-1:0] fetch_beat;
   addr_t [2*N-1:0]  rd_addr;
   data_t [2*N-1:0]  rd_data;
   logic  [2*N-1:0]  rd_hit;

   assign wr_accept = bus.wr_en && (state_q == IDLE) && (bus.wr_addr < ADDR_W'(DEPTH));

   systolic_operand_ram u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_accept),
      .waddr_i (bus.wr_addr),
      .wdata_i (bus.wr_data),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   // Operands are prefetched one beat ahead, so a feed started alongside a write
   // captures beat 0 from the store before that write lands.
   always_comb begin
      fetch_beat = (state_q == FEED) ? cnt_q + 1'b1 : '0;
      for (int l = 0; l < N; l++) begin
         {rd_hit[l],     rd_addr[l]}     = a_lane_rd(int'(fetch_beat), l);
         {rd_hit[N + l], rd_addr[N + l]} = b_lane_rd(int'(fetch_beat), l);
         pre_a_d[l] = rd_hit[l]     ? rd_data[l]     : '0;
         pre_b_d[l] = rd_hit[N + l] ? rd_data[N + l] : '0;
      end
      pre_av_d = rd_hit[N-1:0];
      pre_bv_d = rd_hit[2*N-1:N];
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      a_out_d = '0;
      b_out_d = '0;
      a_vld_d = '0;
      b_vld_d = '0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FEED;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         FEED: begin
            a_out_d = pre_a_q;
            b_out_d = pre_b_q;
            a_vld_d = pre_av_q;
            b_vld_d = pre_bv_q;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(FEED_LEN - 1)) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pre_a_q  <= '0;
         pre_b_q  <= '0;
         pre_av_q <= '0;
         pre_bv_q <= '0;
         a_out_q  <= '0;
         b_out_q  <= '0;
         a_vld_q  <= '0;
         b_vld_q  <= '0;
      end else if (bus.enable) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pre_a_q  <= pre_a_d;
         pre_b_q  <= pre_b_d;
         pre_av_q <= pre_av_d;
         pre_bv_q <= pre_bv_d;
         a_out_q  <= a_out_d;
         b_out_q  <= b_out_d;
         a_vld_q  <= a_vld_d;
         b_vld_q  <= b_vld_d;
      end
   end

   assign bus.a_out   = a_out_q;
   assign bus.b_out   = b_out_q;
   assign bus.a_valid = a_vld_q;
   assign bus.b_valid = b_vld_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
